vga_timing_gen: RTL and testbench

// - Source end of the VGA timing stream consumed by the drawing pipeline (bg/rect/bar stages).
// - Generates hcount/vcount, hsync/vsync and hblnk/vblnk for 1024x768@60 (65 MHz pixel clock).
// - Downstream stages add fixed latency; this block defines pixel (0,0) and frame boundaries.

---
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, sync and blanking for 1024x768@60.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 1024,
  parameter int unsigned H_FP     = 24,
  parameter int unsigned H_SYNC   = 136,
  parameter int unsigned H_BP     = 160,
  parameter int unsigned V_ACTIVE = 768,
  parameter int unsigned V_FP     = 3,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 29
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic [10:0] hcount,
  output logic        hsync,
  output logic        hblnk,
  output logic [10:0] vcount,
  output logic        vsync,
  output logic        vblnk,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_BLK  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END =
    11'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_BLK  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END =
    11'(V_ACTIVE + V_FP + V_SYNC);

  if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_sum
    $error("vga_timing_gen: timing totals exceed 11 bits");
  end

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 ||
      H_BP == 0 || V_ACTIVE == 0 || V_FP == 0 ||
      V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
    $error("vga_timing_gen: zero timing parameter");
  end

  logic [10:0] h_q, h_d;
  logic [10:0] v_q, v_d;
  logic        hs_q, hs_d;
  logic        hb_q, hb_d;
  logic        vs_q, vs_d;
  logic        vb_q, vb_d;
  logic        fs_q, fs_d;
  logic        h_wrap;
  logic        v_wrap;

  // Flags are decoded from the next count pair so the
  // registered count and flags always describe one pixel.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    v_wrap = (v_q == V_LAST);
    h_d    = h_q;
    v_d    = v_q;
    fs_d   = 1'b0;
    if (ce) begin
      h_d = h_wrap ? 11'd0 : h_q + 11'd1;
      if (h_wrap) begin
        v_d = v_wrap ? 11'd0 : v_q + 11'd1;
      end
      fs_d = h_wrap && v_wrap;
    end
    hb_d = (h_d >= H_BLK);
    hs_d = (h_d >= HS_BEG) && (h_d < HS_END);
    vb_d = (v_d >= V_BLK);
    vs_d = (v_d >= VS_BEG) && (v_d < VS_END);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q  <= '0;
      v_q  <= '0;
      hs_q <= 1'b0;
      hb_q <= 1'b0;
      vs_q <= 1'b0;
      vb_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      h_q  <= h_d;
      v_q  <= v_d;
      hs_q <= hs_d;
      hb_q <= hb_d;
      vs_q <= vs_d;
      vb_q <= vb_d;
      fs_q <= fs_d;
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hs_q;
  assign hblnk       = hb_q;
  assign vsync       = vs_q;
  assign vblnk       = vb_q;
  assign frame_start = fs_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q <= '0;
    end else if (fs_d) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_cnt = fc_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: full-size instance for line timing,
// shrunken instance for frame, stall and reset behaviour.
module tb_vga_timing_gen;

  localparam logic [4:0] HS = 5'b10000;
  localparam logic [4:0] HB = 5'b01000;
  localparam logic [4:0] VS = 5'b00100;
  localparam logic [4:0] VB = 5'b00010;
  localparam logic [4:0] FS = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, ce0, rst1, ce1;
  logic [10:0] h0, v0, h1, v1;
  logic hs0, hb0, vs0, vb0, fs0;
  logic hs1, hb1, vs1, vb1, fs1;
  logic [15:0] fc0, fc1;

`ifndef VGA_TIMING_FRAME_CNT_EN
  assign fc0 = 16'h0;
  assign fc1 = 16'h0;
`endif

  vga_timing_gen dut0 (
    .clk(clk), .rst(rst0), .ce(ce0),
    .hcount(h0), .hsync(hs0), .hblnk(hb0),
    .vcount(v0), .vsync(vs0), .vblnk(vb0),
    .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc0)
`endif
  );

  // H_TOTAL = 16 (hsync 10..12), V_TOTAL = 10 (vsync 7..8)
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .ce(ce1),
    .hcount(h1), .hsync(hs1), .hblnk(hb1),
    .vcount(v1), .vsync(vs1), .vblnk(vb1),
    .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc1)
`endif
  );

  typedef struct {
    int unsigned cyc;
    bit          sel;
    logic [10:0] h;
    logic [10:0] v;
    logic [4:0]  fl;
    logic [15:0] fc;
    string       nm;
  } exp_t;

  exp_t q[$];
  int unsigned ne = 0;
  int checks = 0;
  int errors = 0;
  int pos[2];

  task automatic push(input bit s, input int unsigned tag,
                      input int h, input int v,
                      input logic [4:0] fl, input int fc,
                      input string nm);
    exp_t e;
    e.cyc = tag;
    e.sel = s;
    e.h   = 11'(h);
    e.v   = 11'(v);
    e.fl  = fl;
    e.fc  = 16'(fc);
    e.nm  = nm;
    q.push_back(e);
  endtask

  // Expect the next edge to show the given outputs.
  task automatic next(input bit s, input int h, input int v,
                      input logic [4:0] fl, input int fc,
                      input string nm);
    push(s, ne + 1, h, v, fl, fc, nm);
    @(negedge clk);
  endtask

  // Run free until position (f, v, h) and expect it there.
  task automatic go(input bit s, input int f, input int h,
                    input int v, input logic [4:0] fl,
                    input int fc, input string nm);
    int ht, vt, lin, d;
    ht  = s ? 16 : 1344;
    vt  = s ? 10 : 806;
    lin = f * ht * vt + v * ht + h;
    d   = lin - pos[s];
    if (d < 1) begin
      $display("FAIL %s: target behind position (%0d)", nm, d);
      $fatal(1);
    end
    push(s, ne + 32'(d), h, v, fl, fc, nm);
    repeat (d) @(negedge clk);
    pos[s] = lin;
  endtask

  exp_t        e;
  logic [10:0] ah, av;
  logic [4:0]  af;
  logic [15:0] afc;
  bit          ok;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ne++;
      while (q.size() > 0 && q[0].cyc <= ne) begin
        e   = q.pop_front();
        ah  = e.sel ? h1 : h0;
        av  = e.sel ? v1 : v0;
        af  = e.sel ? {hs1, hb1, vs1, vb1, fs1}
                    : {hs0, hb0, vs0, vb0, fs0};
        afc = e.sel ? fc1 : fc0;
        ok  = ({ah, av, af} === {e.h, e.v, e.fl});
`ifdef VGA_TIMING_FRAME_CNT_EN
        ok  = ok && (afc === e.fc);
`endif
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got h=%0d v=%0d fl=%b fc=%0d, want h=%0d v=%0d fl=%b fc=%0d",
                   e.nm, ah, av, af, afc, e.h, e.v, e.fl, e.fc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; ce0 = 1'b1;
    rst1 = 1'b1; ce1 = 1'b0;
    pos[0] = 0; pos[1] = 0;

    for (int i = 0; i < 5; i++)
      next(0, 0, 0, 5'b0, 0, "reset hold");
    rst0 = 1'b0;
    go(0, 0, 1,    0, 5'b0,    0, "first count");
    go(0, 0, 1023, 0, 5'b0,    0, "last active px");
    go(0, 0, 1024, 0, HB,      0, "hblnk rise");
    go(0, 0, 1047, 0, HB,      0, "before hsync");
    go(0, 0, 1048, 0, HB | HS, 0, "hsync start");
    go(0, 0, 1183, 0, HB | HS, 0, "hsync end");
    go(0, 0, 1184, 0, HB,      0, "after hsync");
    go(0, 0, 1343, 0, HB,      0, "line end");
    go(0, 0, 0,    1, 5'b0,    0, "line wrap");
    rst0 = 1'b1;

    ce1 = 1'b1;
    next(1, 0, 0, 5'b0, 0, "small reset");
    rst1 = 1'b0;
    go(1, 0, 1,  0, 5'b0,         0, "s first");
    go(1, 0, 8,  0, HB,           0, "s hblnk");
    go(1, 0, 10, 0, HB | HS,      0, "s hsync start");
    go(1, 0, 12, 0, HB | HS,      0, "s hsync end");
    go(1, 0, 13, 0, HB,           0, "s hsync off");
    go(1, 0, 15, 5, HB,           0, "s last active line");
    go(1, 0, 0,  6, VB,           0, "s vblnk rise");
    go(1, 0, 0,  7, VB | VS,      0, "s vsync start");
    go(1, 0, 15, 8, HB | VB | VS, 0, "s vsync end");
    go(1, 0, 0,  9, VB,           0, "s vsync off");
    go(1, 0, 15, 9, HB | VB,      0, "s frame end");
    go(1, 1, 0,  0, FS,           1, "s frame start");
    go(1, 1, 1,  0, 5'b0,         1, "s fs one cycle");
    go(1, 1, 15, 9, HB | VB,      1, "s pre stall");

    ce1 = 1'b0;
    for (int i = 0; i < 7; i++)
      next(1, 15, 9, HB | VB, 1, "s stall hold");
    ce1 = 1'b1;
    go(1, 2, 0, 0, FS,   2, "s resume fs");
    go(1, 2, 5, 3, 5'b0, 2, "s mid frame");

    rst1 = 1'b1;
    next(1, 0, 0, 5'b0, 0, "s mid reset");
    rst1 = 1'b0;
    pos[1] = 0;
    go(1, 0, 1, 0, 5'b0, 0, "s restart");
    go(1, 0, 0, 1, 5'b0, 0, "s restart line");
    go(1, 1, 0, 0, FS,   1, "s frame 1");
    go(1, 2, 0, 0, FS,   2, "s frame 2");
    go(1, 3, 0, 0, FS,   3, "s frame 3");
    go(1, 3, 1, 0, 5'b0, 3, "s after frame 3");

    repeat (3) @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never compared, want h=%0d v=%0d",
               e.nm, e.h, e.v);
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
